// File: rtl/gold_pkg.sv
// Shared types and constants for the gold bag controllers.
package gold_pkg;

  typedef enum logic [2:0] {
    REST   = 3'd0,
    WOBBLE = 3'd1,
    FALL   = 3'd2,
    BROKEN = 3'd3,
    GONE   = 3'd4
  } gold_state_t;

  localparam int TILE_SIZE     = 32;
  localparam int WOBBLE_TOGGLE = 4;

endpackage

// File: rtl/gold_bag_ctrl.sv
// Per-bag rest/wobble/fall/break/collect lifecycle, advanced once per frame;
// registered outputs change the cycle after the startOfFrame that moved them.
module gold_bag_ctrl
  import gold_pkg::*;
#(
  parameter logic [10:0] INIT_X         = 11'd160,
  parameter logic [10:0] INIT_Y         = 11'd224,
  parameter logic [10:0] BOARD_Y        = 11'd160,
  parameter logic [10:0] BOARD_BOTTOM_Y = 11'd448,
  parameter int          WOBBLE_FRAMES  = 30,
  parameter int          FALL_SPEED     = 4,
  parameter int          BREAK_DIST     = 32,
  parameter int          BROKEN_FRAMES  = 150
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        gold_can_fall,
  input  logic        player_collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        gold_visible,
  output logic        gold_broken,
  output logic        wobble_phase,
  output logic        crush_hazard,
  output logic        gold_collected
);

  gold_state_t state;
  logic [7:0]  frameCnt;
  logic [8:0]  fallDist;
  logic [9:0]  fallSum;
  logic [10:0] yOffset;
  logic        tileAligned;
  logic        atBottom;
  logic        landNow;

  // Landing is only considered on tile boundaries, which absorbs the
  // one-frame lag of the terrain's can_fall answer.
  assign yOffset     = topLeftY - BOARD_Y;
  assign tileAligned = (yOffset & 11'(TILE_SIZE - 1)) == 11'd0;
  assign atBottom    = topLeftY == BOARD_BOTTOM_Y;
  assign landNow     = tileAligned && (!gold_can_fall || atBottom);
  assign fallSum     = {1'b0, fallDist} + 10'(FALL_SPEED);

  assign topLeftX     = INIT_X;
  assign gold_visible = state != GONE;
  assign gold_broken  = state == BROKEN;
  assign crush_hazard = state == FALL;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= REST;
      topLeftY       <= INIT_Y;
      frameCnt       <= 8'd0;
      fallDist       <= 9'd0;
      wobble_phase   <= 1'b0;
      gold_collected <= 1'b0;
    end else begin
      gold_collected <= 1'b0;
      if (startOfFrame) begin
        case (state)
          REST: begin
            if (gold_can_fall) begin
              state        <= WOBBLE;
              frameCnt     <= 8'd0;
              wobble_phase <= 1'b0;
            end
          end
          WOBBLE: begin
            if (!gold_can_fall) begin
              state        <= REST;
              frameCnt     <= 8'd0;
              wobble_phase <= 1'b0;
            end else if (frameCnt == 8'(WOBBLE_FRAMES - 1)) begin
              state        <= FALL;
              frameCnt     <= 8'd0;
              fallDist     <= 9'd0;
              wobble_phase <= 1'b0;
            end else begin
              frameCnt <= frameCnt + 8'd1;
              if (((frameCnt + 8'd1) % 8'(WOBBLE_TOGGLE)) == 8'd0)
                wobble_phase <= ~wobble_phase;
            end
          end
          FALL: begin
            if (landNow) begin
              frameCnt <= 8'd0;
              state    <= (fallDist >= 9'(BREAK_DIST)) ? BROKEN : REST;
            end else begin
              topLeftY <= topLeftY + 11'(FALL_SPEED);
              fallDist <= fallSum[9] ? 9'd511 : fallSum[8:0];
            end
          end
          BROKEN: begin
            // Collection wins over a coinciding timeout so the score is kept.
            if (player_collision) begin
              state          <= GONE;
              frameCnt       <= 8'd0;
              gold_collected <= 1'b1;
            end else if (frameCnt == 8'(BROKEN_FRAMES - 1)) begin
              state    <= GONE;
              frameCnt <= 8'd0;
            end else begin
              frameCnt <= frameCnt + 8'd1;
            end
          end
          GONE: ;
          default: state <= GONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gold_bag_ctrl.sv
// Directed bench for gold_bag_ctrl: two instances, one at the default start
// position and one starting near the board bottom.
module tb_gold_bag_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        rstN2 = 1'b0;
  logic        sof = 1'b0;
  logic        canFall = 1'b0;
  logic        coll = 1'b0;
  logic        canFall2 = 1'b0;
  logic        coll2 = 1'b0;
  logic [10:0] x1, y1, x2, y2;
  logic        vis1, brk1, wob1, crush1, col1;
  logic        vis2, brk2, wob2, crush2, col2;

  int total = 0;
  int bad = 0;
  int pulse1 = 0;
  int pulse2 = 0;
  int p1Start;

  always #5 clk = ~clk;

  gold_bag_ctrl u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .gold_can_fall(canFall), .player_collision(coll),
    .topLeftX(x1), .topLeftY(y1), .gold_visible(vis1), .gold_broken(brk1),
    .wobble_phase(wob1), .crush_hazard(crush1), .gold_collected(col1)
  );

  gold_bag_ctrl #(.INIT_Y(11'd416)) u_dut2 (
    .clk(clk), .resetN(rstN2), .startOfFrame(sof),
    .gold_can_fall(canFall2), .player_collision(coll2),
    .topLeftX(x2), .topLeftY(y2), .gold_visible(vis2), .gold_broken(brk2),
    .wobble_phase(wob2), .crush_hazard(crush2), .gold_collected(col2)
  );

  always @(negedge clk) begin
    if (col1 === 1'b1) pulse1++;
    if (col2 === 1'b1) pulse2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One idle cycle, then a startOfFrame cycle; returns #1 after its edge.
  task automatic frame();
    @(posedge clk); #1;
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic rst1();
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    chk("rst_x", x1, 160);
    chk("rst_y", y1, 224);
    chk("rst_visible", vis1, 1);
    chk("rst_broken", brk1, 0);
    chk("rst_wobble", wob1, 0);
    chk("rst_crush", crush1, 0);
    chk("rst_collected", col1, 0);

    // Held in REST for 100 frames; collision ignored
    canFall = 1'b0;
    coll = 1'b1;
    repeat (100) frame();
    coll = 1'b0;
    chk("rest_y", y1, 224);
    chk("rest_visible", vis1, 1);
    chk("rest_crush", crush1, 0);
    chk("rest_broken", brk1, 0);
    chk("rest_pulse", pulse1, 0);

    // Wobble: 30 frames, phase flips after 4 wobble frames
    canFall = 1'b1;
    frame();
    chk("wob_entry_phase", wob1, 0);
    repeat (3) frame();
    chk("wob_phase_f4", wob1, 0);
    frame();
    chk("wob_phase_f5", wob1, 1);
    repeat (25) frame();
    chk("wob_f30_crush", crush1, 0);
    chk("wob_f30_y", y1, 224);
    frame();
    chk("fall_entry_crush", crush1, 1);
    chk("fall_entry_y", y1, 224);
    chk("fall_entry_phase", wob1, 0);

    // Fall 4 px/frame, cut can_fall at Y=256 -> break
    frame();
    chk("fall_y228", y1, 228);
    repeat (7) frame();
    chk("fall_y256", y1, 256);
    canFall = 1'b0;
    frame();
    chk("land256_broken", brk1, 1);
    chk("land256_crush", crush1, 0);
    chk("land256_y", y1, 256);

    // Collect on BROKEN frame 10
    repeat (9) frame();
    chk("brk_f9_broken", brk1, 1);
    p1Start = pulse1;
    coll = 1'b1;
    frame();
    coll = 1'b0;
    chk("collect_pulse", col1, 1);
    chk("collect_visible", vis1, 0);
    chk("collect_broken", brk1, 0);
    @(posedge clk); #1;
    chk("collect_pulse_end", col1, 0);
    coll = 1'b1;
    repeat (3) frame();
    coll = 1'b0;
    chk("gone_visible", vis1, 0);
    chk("collect_pulse_count", pulse1 - p1Start, 1);

    // Cut at Y=240: unaligned, keeps falling to 256
    rst1();
    chk("rst2_visible", vis1, 1);
    chk("rst2_y", y1, 224);
    canFall = 1'b1;
    repeat (31) frame();
    repeat (4) frame();
    chk("cut_y240", y1, 240);
    canFall = 1'b0;
    frame();
    chk("cut_y244", y1, 244);
    chk("cut_crush", crush1, 1);
    repeat (3) frame();
    chk("cut_y256", y1, 256);
    chk("cut_not_broken", brk1, 0);
    frame();
    chk("cut_broken", brk1, 1);
    chk("cut_land_y", y1, 256);

    // Collision coinciding with timeout frame -> collected with pulse
    p1Start = pulse1;
    repeat (149) frame();
    chk("brk_f149_visible", vis1, 1);
    coll = 1'b1;
    frame();
    coll = 1'b0;
    chk("tie_pulse", col1, 1);
    chk("tie_visible", vis1, 0);
    @(posedge clk); #1;
    chk("tie_pulse_count", pulse1 - p1Start, 1);

    // Landing after less than BREAK_DIST -> REST, not BROKEN
    rst1();
    canFall = 1'b1;
    repeat (31) frame();
    chk("short_fall_crush", crush1, 1);
    canFall = 1'b0;
    frame();
    chk("short_land_crush", crush1, 0);
    chk("short_land_broken", brk1, 0);
    chk("short_land_y", y1, 224);

    // Wobble abort on frame 15, then a full 30-frame wobble again
    rst1();
    canFall = 1'b1;
    repeat (15) frame();
    canFall = 1'b0;
    frame();
    chk("abort_y", y1, 224);
    chk("abort_phase", wob1, 0);
    chk("abort_crush", crush1, 0);
    canFall = 1'b1;
    repeat (30) frame();
    chk("rewob_f30_crush", crush1, 0);
    frame();
    chk("rewob_fall_crush", crush1, 1);

    // Asynchronous reset mid-fall
    repeat (3) frame();
    chk("midfall_y", y1, 236);
    p1Start = pulse1;
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_y", y1, 224);
    chk("async_rst_x", x1, 160);
    chk("async_rst_crush", crush1, 0);
    chk("async_rst_visible", vis1, 1);
    @(posedge clk); #1;
    resetN = 1'b1;
    chk("async_rst_pulse", pulse1 - p1Start, 0);

    // Second bag: clamps at the board bottom with can_fall held high
    rstN2 = 1'b1;
    canFall = 1'b0;
    chk("b2_rst_y", y2, 416);
    canFall2 = 1'b1;
    repeat (31) frame();
    chk("b2_fall_crush", crush2, 1);
    repeat (8) frame();
    chk("b2_y448", y2, 448);
    chk("b2_y448_crush", crush2, 1);
    frame();
    chk("b2_clamp_broken", brk2, 1);
    chk("b2_clamp_y", y2, 448);
    chk("b2_clamp_crush", crush2, 0);

    // No collection -> gone after 150 frames, no pulse
    repeat (149) frame();
    chk("b2_f149_broken", brk2, 1);
    frame();
    chk("b2_timeout_visible", vis2, 0);
    chk("b2_timeout_broken", brk2, 0);
    @(posedge clk); #1;
    chk("b2_no_pulse", pulse2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gold_bag_ctrl.md
# gold_bag_ctrl

Per-bag controller for one gold bag on the terrain board: the requester side of the terrain's gold-fall query. It drives the bag's top-left coordinate into the terrain block, consumes the returned `can_fall` answer, and runs the rest → wobble → fall → break → collect lifecycle once per video frame. It also provides the drawing and collision flags used by the gold sprite, the scoring logic and player/alien hit logic.

## Interface
Parameters:
- `INIT_X`, 11'd160: reset top-left X; must be tile-aligned.
- `INIT_Y`, 11'd224: reset top-left Y; must be tile-aligned.
- `BOARD_Y`, 11'd160: board top Y, the tile grid origin.
- `BOARD_BOTTOM_Y`, 11'd448: largest legal top-left Y (`BOARD_Y + 320 − 32`).
- `WOBBLE_FRAMES`, 30: frames spent wobbling before the bag drops.
- `FALL_SPEED`, 4: pixels per frame while falling; must divide 32.
- `BREAK_DIST`, 32: fall distance in pixels at or above which the bag breaks on landing.
- `BROKEN_FRAMES`, 150: frames a broken pile stays collectible.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle pulse per frame.
- `gold_can_fall`, in, 1: terrain answer; the tile below the current position is empty.
- `player_collision`, in, 1: player sprite overlaps the bag.
- `topLeftX`, out, 11: bag X, fed to terrain `gold_*_top_leftX`.
- `topLeftY`, out, 11: bag Y, fed to terrain `gold_*_top_leftY`.
- `gold_visible`, out, 1: draw the bag or pile.
- `gold_broken`, out, 1: select the pile bitmap.
- `wobble_phase`, out, 1: sprite ±2 px shift select.
- `crush_hazard`, out, 1: bag is falling; kills any sprite it overlaps.
- `gold_collected`, out, 1: one-cycle pulse when the pile is collected.

## Operation
- Reset is the single decided fact for clocking: one clock; reset is asynchronous and active-low.
- State and all counters advance only on cycles where `startOfFrame` = 1. All inputs are sampled on that same cycle.
- Reset values:
  - State = REST.
  - `topLeftX` = `INIT_X`, `topLeftY` = `INIT_Y`.
  - Frame counter = 0, fall-distance counter = 0.
  - `gold_visible` = 1; all other outputs = 0.
- REST:
  - If `gold_can_fall` = 1, clear the frame counter and go to WOBBLE.
  - `player_collision` is ignored in this state.
- WOBBLE:
  - `wobble_phase` toggles every 4 frames.
  - If `gold_can_fall` = 0, return to REST.
  - When the frame counter reaches `WOBBLE_FRAMES − 1`, clear the fall distance and go to FALL.
- FALL:
  - `crush_hazard` = 1.
  - Each frame, if Y is tile-aligned (`(Y − BOARD_Y) mod 32 = 0`) and either `gold_can_fall` = 0 or Y = `BOARD_BOTTOM_Y`, the bag lands:
    - fall distance ≥ `BREAK_DIST` → BROKEN, with the frame counter cleared;
    - otherwise → REST.
  - If the bag does not land, Y += `FALL_SPEED` and fall distance += `FALL_SPEED`.
  - The fall-distance counter is 9 bits and saturates at 511.
- BROKEN:
  - `gold_broken` = 1.
  - `player_collision` = 1 → GONE, with `gold_collected` pulsed.
  - Frame counter reaches `BROKEN_FRAMES − 1` with no collection → GONE, no pulse.
- GONE: `gold_visible` = 0. The state is terminal until reset.
- X never changes.

## Timing
- Outputs are registered. A transition taken on a `startOfFrame` cycle is visible on the following cycle.
- `gold_collected` is high for exactly one clock: the cycle after the collecting `startOfFrame`.
- Terrain `can_fall` reflects the position registered on the previous frame, so the bag has one frame of look-ahead latency. Landing checks are made only at tile-aligned Y, which makes this latency safe.
- Simultaneous events on one frame:
  - In BROKEN, collision and timeout together → collected, with the pulse.
  - In FALL, bottom clamp and `can_fall` = 1 together → land.
- Reset asserted mid-fall immediately restores INIT position and REST, with no pulse.
- Frame counter: 8 bits, cleared on every state entry.

## Structure
- Shared package `gold_pkg` holds:
  - the state enum `gold_state_t` {REST, WOBBLE, FALL, BROKEN, GONE};
  - `TILE_SIZE` = 32;
  - `WOBBLE_TOGGLE` = 4.
- Single module, no sub-module.
- One instance per bag, with its position ports wired to the matching terrain `gold_*_top_left*` pair.

## Test plan
- Reset, then hold `gold_can_fall` = 0 for 100 frames → stays REST at (160, 224), `gold_visible` = 1, all other flags 0.
- `gold_can_fall` = 1 constantly → WOBBLE for 30 frames; then FALL, with Y advancing 4 px per frame and `crush_hazard` = 1.
- Fall from Y = 224, drop `can_fall` when Y = 256 → lands at 256 after 32 px of fall → BROKEN, `gold_broken` = 1. Repeat with the cut at Y = 240 → no landing until 256, same result.
- Start at Y = 416 with `can_fall` = 1 throughout → clamps at 448, lands, 32 px fallen → BROKEN.
- In BROKEN, pulse `player_collision` on frame 10 → `gold_collected` high exactly one cycle, `gold_visible` = 0. A separate run with no collision → GONE after 150 frames, no pulse.
- Drop `can_fall` on wobble frame 15 → REST, Y unchanged. Assert `resetN` = 0 mid-fall → outputs return to (160, 224) asynchronously.
